// File: rtl/triangle_pkg.sv
// Shared types for the triangle-wave tracker.
package triangle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK_UP,
        TRACK_DOWN
    } state_t;

endpackage

// File: rtl/triangle_generator.sv
// Reference triangle source: counts 0 up to 2^N-1, back down to 0, and repeats; advances only when ena=1.
module triangle_generator #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    output logic [N-1:0] out
);

    localparam logic [N-1:0] MAX = '1;

    logic going_down;

    always_ff @(posedge clk) begin
        if (rst) begin
            out        <= '0;
            going_down <= 1'b0;
        end else if (ena) begin
            if (!going_down) begin
                if (out == MAX) begin
                    going_down <= 1'b1;
                    out        <= MAX - 1'b1;
                end else begin
                    out <= out + 1'b1;
                end
            end else begin
                if (out == '0) begin
                    going_down <= 1'b0;
                    out        <= {{(N-1){1'b0}}, 1'b1};
                end else begin
                    out <= out - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/triangle_tracker.sv
// Locks onto a unit-step triangle wave, flags peaks/troughs and broken steps,
// and measures the step count between successive turning points.
module triangle_tracker #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] in,
    output logic         dir,
    output logic         at_peak,
    output logic         at_trough,
    output logic [N-1:0] half_period,
    output logic         locked,
    output logic         step_err,
    output logic [7:0]   err_count
);

    import triangle_pkg::*;

    localparam logic [N-1:0] MAX = '1;

    state_t       state, state_next;
    logic [N-1:0] prev, prev_next;
    logic [N-1:0] cnt, cnt_next;
    logic         seen_turn, seen_next;
    logic         locked_next, dir_next;
    logic         peak_next, trough_next, step_err_next;
    logic [N-1:0] half_next;
    logic [7:0]   err_next;

    // Steps are compared one bit wider so that 2^N-1 -> 0 and 0 -> 2^N-1 never look legal.
    logic [N:0] in_ext, prev_ext;
    logic       up_step, down_step, turn, bad;

    assign in_ext    = {1'b0, in};
    assign prev_ext  = {1'b0, prev};
    assign up_step   = (in_ext == prev_ext + 1'b1);
    assign down_step = (in_ext + 1'b1 == prev_ext);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            prev        <= '0;
            cnt         <= '0;
            seen_turn   <= 1'b0;
            locked      <= 1'b0;
            half_period <= '0;
            err_count   <= '0;
            dir         <= 1'b0;
            at_peak     <= 1'b0;
            at_trough   <= 1'b0;
            step_err    <= 1'b0;
        end else begin
            state       <= state_next;
            prev        <= prev_next;
            cnt         <= cnt_next;
            seen_turn   <= seen_next;
            locked      <= locked_next;
            half_period <= half_next;
            err_count   <= err_next;
            dir         <= dir_next;
            at_peak     <= peak_next;
            at_trough   <= trough_next;
            step_err    <= step_err_next;
        end
    end

    always_comb begin
        state_next    = state;
        prev_next     = prev;
        cnt_next      = cnt;
        seen_next     = seen_turn;
        locked_next   = locked;
        half_next     = half_period;
        err_next      = err_count;
        dir_next      = dir;
        peak_next     = 1'b0;
        trough_next   = 1'b0;
        step_err_next = 1'b0;
        turn          = 1'b0;
        bad           = 1'b0;

        if (ena) begin
            prev_next = in;
            case (state)
                IDLE: begin
                    state_next = ACQUIRE;
                end
                ACQUIRE: begin
                    if (up_step) begin
                        if (in == MAX) begin
                            peak_next  = 1'b1;
                            turn       = 1'b1;
                            state_next = TRACK_DOWN;
                        end else begin
                            state_next = TRACK_UP;
                        end
                    end else if (down_step) begin
                        if (in == '0) begin
                            trough_next = 1'b1;
                            turn        = 1'b1;
                            state_next  = TRACK_UP;
                        end else begin
                            state_next = TRACK_DOWN;
                        end
                    end else begin
                        bad = 1'b1;
                    end
                end
                TRACK_UP: begin
                    if (!up_step) begin
                        bad = 1'b1;
                    end else if (in == MAX) begin
                        peak_next  = 1'b1;
                        turn       = 1'b1;
                        state_next = TRACK_DOWN;
                    end else if (cnt != MAX) begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                TRACK_DOWN: begin
                    if (!down_step) begin
                        bad = 1'b1;
                    end else if (in == '0) begin
                        trough_next = 1'b1;
                        turn        = 1'b1;
                        state_next  = TRACK_UP;
                    end else if (cnt != MAX) begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            // Only the second and later turning points since acquisition measure a full half period.
            if (turn) begin
                cnt_next = '0;
                if (seen_turn) begin
                    half_next   = (cnt == MAX) ? MAX : cnt + 1'b1;
                    locked_next = 1'b1;
                end else begin
                    seen_next = 1'b1;
                end
            end

            if (bad) begin
                step_err_next = 1'b1;
                state_next    = ACQUIRE;
                locked_next   = 1'b0;
                cnt_next      = '0;
                seen_next     = 1'b0;
                if (err_count != 8'hFF) begin
                    err_next = err_count + 8'd1;
                end
            end

            dir_next = (state_next == TRACK_DOWN);
        end
    end

endmodule

// File: tb/tb_triangle_tracker.sv
// Directed scenario bench for triangle_tracker, fed either from triangle_generator or by hand.
module tb_triangle_tracker;

    import triangle_pkg::*;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         gen_rst;
    logic         ena;
    logic         use_gen;
    logic [N-1:0] tb_in;
    logic [N-1:0] gen_out;
    logic [N-1:0] trk_in;
    logic         dir;
    logic         at_peak;
    logic         at_trough;
    logic [N-1:0] half_period;
    logic         locked;
    logic         step_err;
    logic [7:0]   err_count;

    int checks = 0;
    int errors = 0;

    assign trk_in = use_gen ? gen_out : tb_in;

    triangle_generator #(.N(N)) gen (
        .clk (clk),
        .rst (gen_rst),
        .ena (ena),
        .out (gen_out)
    );

    triangle_tracker #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .in          (trk_in),
        .dir         (dir),
        .at_peak     (at_peak),
        .at_trough   (at_trough),
        .half_period (half_period),
        .locked      (locked),
        .step_err    (step_err),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs and return 1 time unit after the rising edge.
    task automatic apply_stimulus(input logic e, input logic [N-1:0] s);
        ena   = e;
        tb_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        gen_rst = 1'b1;
        apply_stimulus(1'b0, '0);
        apply_stimulus(1'b0, '0);
        rst     = 1'b0;
        gen_rst = 1'b0;
    endtask

    task automatic test_reset();
        use_gen = 1'b0;
        rst     = 1'b1;
        gen_rst = 1'b1;
        apply_stimulus(1'b1, 8'd37);
        apply_stimulus(1'b1, 8'd38);
        checks++;
        if ({dir, at_peak, at_trough, locked, step_err} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b, expected 00000", {dir, at_peak, at_trough, locked, step_err});
        end
        checks++;
        if (half_period !== 8'd0 || err_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_counts: got hp=%0d ec=%0d, expected 0 0", half_period, err_count);
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("[TB] FAIL reset_state: got %0d, expected %0d", dut.state, IDLE);
        end
        rst     = 1'b0;
        gen_rst = 1'b0;
    endtask

    task automatic test_stream();
        logic exp_dir;
        do_reset();
        use_gen = 1'b1;
        for (int i = 0; i < 511; i++) begin
            apply_stimulus(1'b1, '0);
            exp_dir = (i >= 255 && i < 510);
            checks++;
            if (at_peak !== (i == 255)) begin
                errors++;
                $display("[TB] FAIL stream_peak[%0d]: got %b, expected %b", i, at_peak, (i == 255));
            end
            checks++;
            if (at_trough !== (i == 510)) begin
                errors++;
                $display("[TB] FAIL stream_trough[%0d]: got %b, expected %b", i, at_trough, (i == 510));
            end
            checks++;
            if (dir !== exp_dir) begin
                errors++;
                $display("[TB] FAIL stream_dir[%0d]: got %b, expected %b", i, dir, exp_dir);
            end
            if (i == 255) begin
                checks++;
                if (locked !== 1'b0 || half_period !== 8'd0) begin
                    errors++;
                    $display("[TB] FAIL stream_first_peak: got locked=%b hp=%0d, expected 0 0", locked, half_period);
                end
            end
        end
        checks++;
        if (half_period !== 8'd255 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stream_lock: got hp=%0d locked=%b, expected 255 1", half_period, locked);
        end
        // Break the lock: half_period must survive the error.
        use_gen = 1'b0;
        apply_stimulus(1'b1, 8'd77);
        checks++;
        if (step_err !== 1'b1 || locked !== 1'b0 || half_period !== 8'd255 || dut.state !== ACQUIRE) begin
            errors++;
            $display("[TB] FAIL stream_break: got err=%b locked=%b hp=%0d st=%0d, expected 1 0 255 %0d",
                     step_err, locked, half_period, dut.state, ACQUIRE);
        end
    endtask

    task automatic test_ena_toggle();
        int  j;
        logic e;
        logic exp_peak, exp_trough, exp_dir;
        do_reset();
        use_gen = 1'b1;
        j = 0;
        exp_dir = 1'b0;
        for (int c = 0; c < 1100 && j < 511; c++) begin
            e = (c % 2 == 0);
            apply_stimulus(e, '0);
            exp_peak   = 1'b0;
            exp_trough = 1'b0;
            if (e) begin
                exp_peak   = (j == 255);
                exp_trough = (j == 510);
                exp_dir    = (j >= 255 && j < 510);
                j++;
            end
            checks++;
            if (at_peak !== exp_peak || at_trough !== exp_trough) begin
                errors++;
                $display("[TB] FAIL toggle_pulse[c=%0d]: got pk=%b tr=%b, expected %b %b",
                         c, at_peak, at_trough, exp_peak, exp_trough);
            end
            checks++;
            if (dir !== exp_dir) begin
                errors++;
                $display("[TB] FAIL toggle_dir[c=%0d]: got %b, expected %b", c, dir, exp_dir);
            end
        end
        checks++;
        if (half_period !== 8'd255 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL toggle_lock: got hp=%0d locked=%b, expected 255 1", half_period, locked);
        end
    endtask

    task automatic test_step_error();
        do_reset();
        use_gen = 1'b0;
        apply_stimulus(1'b1, 8'd10);
        apply_stimulus(1'b1, 8'd11);
        checks++;
        if (dut.state !== TRACK_UP) begin
            errors++;
            $display("[TB] FAIL err_acq_up: got %0d, expected %0d", dut.state, TRACK_UP);
        end
        apply_stimulus(1'b1, 8'd12);
        checks++;
        if (step_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_none: got %b, expected 0", step_err);
        end
        apply_stimulus(1'b1, 8'd40);
        checks++;
        if (step_err !== 1'b1 || dut.state !== ACQUIRE || err_count !== 8'd1) begin
            errors++;
            $display("[TB] FAIL err_pulse: got err=%b st=%0d ec=%0d, expected 1 %0d 1",
                     step_err, dut.state, err_count, ACQUIRE);
        end
        apply_stimulus(1'b1, 8'd41);
        checks++;
        if (step_err !== 1'b0 || dut.state !== TRACK_UP) begin
            errors++;
            $display("[TB] FAIL err_reacquire: got err=%b st=%0d, expected 0 %0d", step_err, dut.state, TRACK_UP);
        end
        apply_stimulus(1'b1, 8'd42);
        checks++;
        if (err_count !== 8'd1 || locked !== 1'b0 || step_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_final: got ec=%0d locked=%b err=%b, expected 1 0 0", err_count, locked, step_err);
        end
    endtask

    task automatic test_no_wrap();
        do_reset();
        use_gen = 1'b0;
        apply_stimulus(1'b1, 8'd254);
        apply_stimulus(1'b1, 8'd255);
        checks++;
        if (at_peak !== 1'b1 || dir !== 1'b1 || step_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_peak: got pk=%b dir=%b err=%b, expected 1 1 0", at_peak, dir, step_err);
        end
        apply_stimulus(1'b1, 8'd0);
        checks++;
        if (step_err !== 1'b1 || at_peak !== 1'b0 || at_trough !== 1'b0 || dir !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_err: got err=%b pk=%b tr=%b dir=%b, expected 1 0 0 0",
                     step_err, at_peak, at_trough, dir);
        end
    endtask

    task automatic test_err_saturation();
        do_reset();
        use_gen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(1'b1, 8'd100);
            if (i == 200) begin
                checks++;
                if (err_count !== 8'd200) begin
                    errors++;
                    $display("[TB] FAIL sat_mid: got %0d, expected 200", err_count);
                end
            end
        end
        checks++;
        if (err_count !== 8'd255 || step_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_full: got ec=%0d err=%b, expected 255 1", err_count, step_err);
        end
        apply_stimulus(1'b0, 8'd100);
        checks++;
        if (err_count !== 8'd255 || step_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sat_hold: got ec=%0d err=%b, expected 255 0", err_count, step_err);
        end
    endtask

    // Continues from the saturated error count so the reset has something to clear.
    task automatic test_reset_mid_sweep();
        use_gen = 1'b0;
        apply_stimulus(1'b1, 8'd99);
        apply_stimulus(1'b1, 8'd98);
        checks++;
        if (dir !== 1'b1 || dut.state !== TRACK_DOWN) begin
            errors++;
            $display("[TB] FAIL mid_down: got dir=%b st=%0d, expected 1 %0d", dir, dut.state, TRACK_DOWN);
        end
        rst = 1'b1;
        apply_stimulus(1'b1, 8'd97);
        rst = 1'b0;
        checks++;
        if ({dir, at_peak, at_trough, locked, step_err} !== 5'b0 || err_count !== 8'd0 || half_period !== 8'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got flags=%b ec=%0d hp=%0d, expected 00000 0 0",
                     {dir, at_peak, at_trough, locked, step_err}, err_count, half_period);
        end
        apply_stimulus(1'b1, 8'd96);
        checks++;
        if (dut.state !== ACQUIRE || step_err !== 1'b0 || dir !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reacquire: got st=%0d err=%b dir=%b, expected %0d 0 0",
                     dut.state, step_err, dir, ACQUIRE);
        end
    endtask

    initial begin
        rst     = 1'b1;
        gen_rst = 1'b1;
        ena     = 1'b0;
        use_gen = 1'b0;
        tb_in   = '0;
        #1;
        test_reset();
        test_stream();
        test_ena_toggle();
        test_step_error();
        test_no_wrap();
        test_err_saturation();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/triangle_tracker.md
TRIANGLE_TRACKER -- requirements
Module: triangle_tracker

Interface
REQ-001 SHALL have parameter N, default 8, giving the sample width in bits.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-004 SHALL have port ena, input, 1 bit, sample valid; the sample is accepted on any rising edge with ena=1.
REQ-005 SHALL have port in, input, N bits, the triangle sample under test.
REQ-006 SHALL have port dir, output, 1 bit, the tracked direction: 0 means up, 1 means down.
REQ-007 SHALL have port at_peak, output, 1 bit, a one-cycle pulse when sample 2^N-1 is accepted while tracking up.
REQ-008 SHALL have port at_trough, output, 1 bit, a one-cycle pulse when sample 0 is accepted while tracking down.
REQ-009 SHALL have port half_period, output, N bits, the step count between the last two turning points.
REQ-010 SHALL have port locked, output, 1 bit, high once two consecutive turning points are seen with no error between them.
REQ-011 SHALL have port step_err, output, 1 bit, a one-cycle pulse on an unexpected sample.
REQ-012 SHALL have port err_count, output, 8 bits, a saturating count of step errors.

Function
REQ-013 SHALL implement states IDLE, ACQUIRE, TRACK_UP and TRACK_DOWN, with dir=1 only in TRACK_DOWN.
REQ-014 SHALL hold every register when ena=0, and drive at_peak, at_trough and step_err to 0.
REQ-015 SHALL register all outputs; a pulse caused by the sample accepted at edge k is high for exactly the cycle following edge k.
REQ-016 IDLE: SHALL store the accepted sample as prev and go to ACQUIRE.
REQ-017 ACQUIRE: SHALL go to TRACK_UP if in==prev+1, and to TRACK_DOWN if in==prev-1; any other sample pulses step_err, updates prev and stays in ACQUIRE.
REQ-018 TRACK_UP: SHALL accept only in==prev+1; TRACK_DOWN SHALL accept only in==prev-1; modular wrap (2^N-1 to 0, or 0 to 2^N-1) counts as an error.
REQ-019 SHALL treat acceptance of 2^N-1 while moving up (including the ACQUIRE resolution) as a peak: pulse at_peak and go to TRACK_DOWN.
REQ-020 SHALL treat acceptance of 0 while moving down as a trough: pulse at_trough and go to TRACK_UP.
REQ-021 SHALL keep a step counter (N bits, saturating): cleared at each turning point, incremented on each accepted non-turning in-track sample.
REQ-022 At a turning point with a prior turning point since the last ACQUIRE, SHALL set half_period to counter+1 and set locked; the first turning point only sets the seen-turn flag.
REQ-023 On an error in TRACK_UP or TRACK_DOWN, SHALL pulse step_err, set prev to in, clear locked, the step counter and the seen-turn flag, and go to ACQUIRE; half_period SHALL hold.
REQ-024 SHALL increment err_count on every step_err and hold it at 255 once reached.
REQ-025 SHALL always update prev to the accepted sample.

Reset
REQ-026 On rst=1, SHALL enter IDLE and set dir, at_peak, at_trough, step_err, locked, half_period, err_count, prev, the counter and the seen-turn flag to 0.
REQ-027 rst SHALL take priority over ena; reset mid-sweep SHALL discard all tracking history.

Structure
REQ-028 The state_t enum SHALL live in the shared package triangle_pkg.
REQ-029 The block SHALL be a single flat module; no sub-module is warranted.
REQ-030 The bench SHALL drive stimulus from triangle_generator with a matching N.

Verification
REQ-031 Scenario: N=8, ena=1, generator from reset -> at_trough never pulses before the first peak; the first at_peak follows sample 255; at the next trough half_period=255 and locked=1.
REQ-032 Scenario: toggle ena every other cycle on the same stream -> same pulse sequence and half_period=255; no pulse ever appears in an ena=0 cycle.
REQ-033 Scenario: samples 10,11,12,40,41,42 -> step_err pulses once after 40; state returns to ACQUIRE, then TRACK_UP after 41; err_count=1; locked=0.
REQ-034 Scenario: samples 254,255,0 -> at_peak pulses after 255, then step_err after 0 (no wrap); dir=1 until the error.
REQ-035 Scenario: 300 consecutive bad samples -> err_count=255 and holds.
REQ-036 Scenario: rst asserted mid-down-sweep with ena=1 -> all outputs are 0 on the next cycle; the following sample re-enters ACQUIRE.
